// File: rtl/ctrl_wb_multi.sv
// Multi-engine output-buffer write-back sequencer: drains NUM_ENG engines in ascending order per tile.
// Optional macro WB_STALL_CNT_EN adds the wb_stall_cycles busy-but-not-valid counter.
module ctrl_wb_multi #(
   parameter int NUM_ENG = 2,
   parameter int ADDR_W  = 10,
   parameter int BANK_W  = 3,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_ENG*CNT_W-1:0]  eng_out_times,
   input  logic [NUM_ENG*BANK_W-1:0] eng_bank_num,
   input  logic                      wb_tile_start,
   input  logic                      wb_valid_out,
   output logic                      wb_we,
   output logic [NUM_ENG-1:0]        wb_eng_sel,
   output logic [BANK_W-1:0]         wb_bank_sel,
   output logic [ADDR_W-1:0]         wb_addr,
   output logic                      wb_busy,
   output logic                      wb_tile_end,
`ifdef WB_STALL_CNT_EN
   output logic [31:0]               wb_stall_cycles,
`endif
   output logic                      wb_start_err
);

   localparam int EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t                    state_r, state_s;
   logic [EW-1:0]             eng_r, eng_s;
   logic [CNT_W-1:0]          cnt_r, cnt_s;
   logic [BANK_W-1:0]         bank_r, bank_s;
   logic [NUM_ENG*CNT_W-1:0]  times_r;
   logic [NUM_ENG*BANK_W-1:0] banks_r;
   logic                      tile_end_r, tile_end_s;
   logic                      start_err_r, start_err_s;
   logic                      latch_s;

   logic [EW-1:0]             first_s, next_s;
   logic                      first_found_s, next_found_s;
   logic [CNT_W-1:0]          cur_times_s;
   logic [BANK_W-1:0]         cur_bank_num_s;
   logic [BANK_W-1:0]         bank_last_s;
   logic                      last_beat_s;

   // Engine search: first non-empty engine of the incoming tile, next non-empty engine after eng_r
   always_comb begin
      first_s        = '0;
      first_found_s  = 1'b0;
      next_s         = '0;
      next_found_s   = 1'b0;
      cur_times_s    = '0;
      cur_bank_num_s = '0;
      for (int j = 0; j < NUM_ENG; j++) begin
         logic take_first;
         logic take_next;
         logic is_cur;
         take_first     = !first_found_s && (eng_out_times[j*CNT_W +: CNT_W] != '0);
         take_next      = !next_found_s && (j > int'(eng_r)) && (times_r[j*CNT_W +: CNT_W] != '0);
         is_cur         = (eng_r == EW'(j));
         first_s        = take_first ? EW'(j) : first_s;
         first_found_s  = first_found_s | take_first;
         next_s         = take_next ? EW'(j) : next_s;
         next_found_s   = next_found_s | take_next;
         cur_times_s    = is_cur ? times_r[j*CNT_W +: CNT_W] : cur_times_s;
         cur_bank_num_s = is_cur ? banks_r[j*BANK_W +: BANK_W] : cur_bank_num_s;
      end
   end

   // A bank count of zero behaves as a single bank, so the wrap point is bank 0
   assign bank_last_s = (cur_bank_num_s == '0) ? '0 : (cur_bank_num_s - BANK_W'(1));
   assign last_beat_s = (cnt_r == (cur_times_s - CNT_W'(1)));

   // Next-state and pulse decode
   always_comb begin
      state_s     = state_r;
      eng_s       = eng_r;
      cnt_s       = cnt_r;
      bank_s      = bank_r;
      tile_end_s  = 1'b0;
      start_err_s = 1'b0;
      latch_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (wb_tile_start) begin
               latch_s = 1'b1;
               cnt_s   = '0;
               bank_s  = '0;
               if (first_found_s) begin
                  state_s = ST_DRAIN;
                  eng_s   = first_s;
               end else begin
                  tile_end_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            start_err_s = wb_tile_start;
            if (wb_valid_out) begin
               if (last_beat_s) begin
                  cnt_s  = '0;
                  bank_s = '0;
                  if (next_found_s) begin
                     eng_s = next_s;
                  end else begin
                     state_s    = ST_IDLE;
                     eng_s      = '0;
                     tile_end_s = 1'b1;
                  end
               end else begin
                  cnt_s  = cnt_r + CNT_W'(1);
                  bank_s = (bank_r == bank_last_s) ? '0 : (bank_r + BANK_W'(1));
               end
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
            eng_s   = '0;
            cnt_s   = '0;
            bank_s  = '0;
         end
      endcase
   end

   // State and latched tile configuration
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         eng_r       <= '0;
         cnt_r       <= '0;
         bank_r      <= '0;
         times_r     <= '0;
         banks_r     <= '0;
         tile_end_r  <= 1'b0;
         start_err_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         eng_r       <= eng_s;
         cnt_r       <= cnt_s;
         bank_r      <= bank_s;
         tile_end_r  <= tile_end_s;
         start_err_r <= start_err_s;
         if (latch_s) begin
            times_r <= eng_out_times;
            banks_r <= eng_bank_num;
         end
      end
   end

   // One-hot engine select decoded from the registered engine index
   always_comb begin
      wb_eng_sel = '0;
      for (int j = 0; j < NUM_ENG; j++) begin
         wb_eng_sel[j] = (state_r == ST_DRAIN) && (eng_r == EW'(j));
      end
   end

   assign wb_busy      = (state_r == ST_DRAIN);
   assign wb_we        = wb_busy & wb_valid_out;
   assign wb_bank_sel  = bank_r;
   assign wb_addr      = cnt_r[ADDR_W-1:0];
   assign wb_tile_end  = tile_end_r;
   assign wb_start_err = start_err_r;

`ifdef WB_STALL_CNT_EN
   logic [31:0] stall_r;

   // Saturating count of busy cycles without upstream data
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_r <= 32'd0;
      end else if (latch_s) begin
         stall_r <= 32'd0;
      end else if (wb_busy && !wb_valid_out && (stall_r != 32'hFFFF_FFFF)) begin
         stall_r <= stall_r + 32'd1;
      end else begin
         stall_r <= stall_r;
      end
   end

   assign wb_stall_cycles = stall_r;
`endif

endmodule

// File: tb/tb_ctrl_wb_multi.sv
// Table-driven bench for ctrl_wb_multi (NUM_ENG=2), plus a narrow-address instance for wrap checks.
module tb_ctrl_wb_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] eng_out_times;
   logic [5:0]  eng_bank_num;
   logic        wb_tile_start;
   logic        wb_valid_out;

   logic        we1, busy1, end1, err1;
   logic [1:0]  sel1;
   logic [2:0]  bank1;
   logic [9:0]  addr1;
   logic        we2, busy2, end2, err2;
   logic [1:0]  sel2;
   logic [2:0]  bank2;
   logic [1:0]  addr2;
`ifdef WB_STALL_CNT_EN
   logic [31:0] stall1, stall2;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ctrl_wb_multi #(.NUM_ENG(2), .ADDR_W(10), .BANK_W(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .eng_out_times(eng_out_times), .eng_bank_num(eng_bank_num),
      .wb_tile_start(wb_tile_start), .wb_valid_out(wb_valid_out),
      .wb_we(we1), .wb_eng_sel(sel1), .wb_bank_sel(bank1), .wb_addr(addr1),
      .wb_busy(busy1), .wb_tile_end(end1),
`ifdef WB_STALL_CNT_EN
      .wb_stall_cycles(stall1),
`endif
      .wb_start_err(err1)
   );

   ctrl_wb_multi #(.NUM_ENG(2), .ADDR_W(2), .BANK_W(3), .CNT_W(16)) dut_narrow (
      .clk(clk), .rst(rst), .eng_out_times(eng_out_times), .eng_bank_num(eng_bank_num),
      .wb_tile_start(wb_tile_start), .wb_valid_out(wb_valid_out),
      .wb_we(we2), .wb_eng_sel(sel2), .wb_bank_sel(bank2), .wb_addr(addr2),
      .wb_busy(busy2), .wb_tile_end(end2),
`ifdef WB_STALL_CNT_EN
      .wb_stall_cycles(stall2),
`endif
      .wb_start_err(err2)
   );

   typedef struct {
      logic        rst;
      logic        start;
      logic        valid;
      logic [31:0] times;
      logic [5:0]  banks;
      logic [1:0]  sel;
      logic [2:0]  bank;
      logic [9:0]  addr;
      logic        busy;
      logic        we;
      logic        tend;
      logic        err;
   } vec_t;

   vec_t vecs[$];
   int   stall_row = -1;

   function automatic vec_t mk(input logic r, input logic s, input logic v,
                               input logic [31:0] t, input logic [5:0] b,
                               input logic [1:0] sel, input logic [2:0] bk, input logic [9:0] a,
                               input logic bu, input logic we, input logic te, input logic er);
      vec_t x;
      x.rst = r; x.start = s; x.valid = v; x.times = t; x.banks = b;
      x.sel = sel; x.bank = bk; x.addr = a; x.busy = bu; x.we = we; x.tend = te; x.err = er;
      return x;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic ok, input string got, input string want);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %s, want %s", name, got, want);
      end
   endtask

   localparam logic [31:0] T1 = {16'd3, 16'd4};   // engine1=3, engine0=4
   localparam logic [5:0]  B1 = {3'd4, 3'd2};
   localparam logic [31:0] T2 = {16'd5, 16'd0};
   localparam logic [5:0]  B2 = {3'd2, 3'd3};
   localparam logic [31:0] T3 = 32'd0;
   localparam logic [31:0] T4 = {16'd2, 16'd3};
   localparam logic [5:0]  B4 = {3'd1, 3'd1};
   localparam logic [5:0]  B5 = {3'd2, 3'd2};
   localparam logic [31:0] TX = {16'd1, 16'd1};
   localparam logic [31:0] T5 = {16'd3, 16'd2};
   localparam logic [31:0] T6 = {16'd0, 16'd6};
   localparam logic [5:0]  B0 = 6'd0;

   initial begin
      // reset state
      vecs.push_back(mk(1'b0,1'b0,1'b0, T1,B1, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b0,1'b0));
      // basic two-engine tile, valid held high
      vecs.push_back(mk(1'b0,1'b1,1'b0, T1,B1, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T1,B1, 2'd1,3'd0,10'd0, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T1,B1, 2'd1,3'd1,10'd1, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T1,B1, 2'd1,3'd0,10'd2, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T1,B1, 2'd1,3'd1,10'd3, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T1,B1, 2'd2,3'd0,10'd0, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T1,B1, 2'd2,3'd1,10'd1, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T1,B1, 2'd2,3'd2,10'd2, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T1,B1, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b1,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0, T1,B1, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b0,1'b0));
      // engine 0 empty
      vecs.push_back(mk(1'b0,1'b1,1'b0, T2,B2, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T2,B2, 2'd2,3'd0,10'd0, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T2,B2, 2'd2,3'd1,10'd1, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T2,B2, 2'd2,3'd0,10'd2, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T2,B2, 2'd2,3'd1,10'd3, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T2,B2, 2'd2,3'd0,10'd4, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0, T2,B2, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b1,1'b0));
      // all engines empty
      vecs.push_back(mk(1'b0,1'b1,1'b0, T3,B2, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T3,B2, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b1,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T3,B2, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b0,1'b0));
      // toggling valid, single bank
      vecs.push_back(mk(1'b0,1'b1,1'b0, T4,B4, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T4,B4, 2'd1,3'd0,10'd0, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0, T4,B4, 2'd1,3'd0,10'd1, 1'b1,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T4,B4, 2'd1,3'd0,10'd1, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0, T4,B4, 2'd1,3'd0,10'd2, 1'b1,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T4,B4, 2'd1,3'd0,10'd2, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0, T4,B4, 2'd2,3'd0,10'd0, 1'b1,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T4,B4, 2'd2,3'd0,10'd0, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0, T4,B4, 2'd2,3'd0,10'd1, 1'b1,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T4,B4, 2'd2,3'd0,10'd1, 1'b1,1'b1,1'b0,1'b0));
      stall_row = vecs.size();
      vecs.push_back(mk(1'b0,1'b0,1'b0, T4,B4, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b1,1'b0));
      // second start mid-tile is ignored with one error pulse
      vecs.push_back(mk(1'b0,1'b1,1'b0, T4,B5, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T4,B5, 2'd1,3'd0,10'd0, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b1,1'b1, TX,B0, 2'd1,3'd1,10'd1, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, TX,B0, 2'd1,3'd0,10'd2, 1'b1,1'b1,1'b0,1'b1));
      vecs.push_back(mk(1'b0,1'b0,1'b1, TX,B0, 2'd2,3'd0,10'd0, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, TX,B0, 2'd2,3'd1,10'd1, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0, TX,B0, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b1,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0, TX,B0, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b0,1'b0));
      // reset during engine 1, then a clean tile
      vecs.push_back(mk(1'b0,1'b1,1'b0, T5,B1, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T5,B1, 2'd1,3'd0,10'd0, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T5,B1, 2'd1,3'd1,10'd1, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T5,B1, 2'd2,3'd0,10'd0, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T5,B1, 2'd2,3'd1,10'd1, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b1,1'b0,1'b1, T5,B1, 2'd2,3'd2,10'd2, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T5,B1, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0, T5,B1, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b1,1'b0, T5,B1, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T5,B1, 2'd1,3'd0,10'd0, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T5,B1, 2'd1,3'd1,10'd1, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T5,B1, 2'd2,3'd0,10'd0, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T5,B1, 2'd2,3'd1,10'd1, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b1, T5,B1, 2'd2,3'd2,10'd2, 1'b1,1'b1,1'b0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,1'b0, T5,B1, 2'd0,3'd0,10'd0, 1'b0,1'b0,1'b1,1'b0));

      rst = 1'b1; wb_tile_start = 1'b0; wb_valid_out = 1'b0;
      eng_out_times = 32'd0; eng_bank_num = 6'd0;
      step();
      step();

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         v = vecs[i];
         rst = v.rst; wb_tile_start = v.start; wb_valid_out = v.valid;
         eng_out_times = v.times; eng_bank_num = v.banks;
         #4;
         check($sformatf("row%0d", i),
               ({sel1, bank1, addr1, busy1, we1, end1, err1} ===
                {v.sel, v.bank, v.addr, v.busy, v.we, v.tend, v.err}),
               $sformatf("sel=%b bank=%0d addr=%0d busy=%b we=%b end=%b err=%b",
                         sel1, bank1, addr1, busy1, we1, end1, err1),
               $sformatf("sel=%b bank=%0d addr=%0d busy=%b we=%b end=%b err=%b",
                         v.sel, v.bank, v.addr, v.busy, v.we, v.tend, v.err));
`ifdef WB_STALL_CNT_EN
         if (i == stall_row) begin
            check("stall_cycles", stall1 === 32'd4, $sformatf("%0d", stall1), "4");
         end
`endif
         step();
      end

      // narrow address wraps, zero bank count pins bank 0, start on final beat errors
      rst = 1'b0; wb_tile_start = 1'b1; wb_valid_out = 1'b0;
      eng_out_times = T6; eng_bank_num = B0;
      step();
      wb_tile_start = 1'b0; wb_valid_out = 1'b1;
      for (int i = 0; i < 6; i++) begin
         logic [3:0] iv;
         iv = 4'(i);
         wb_tile_start = (i == 5) ? 1'b1 : 1'b0;
         #4;
         check($sformatf("narrow_beat%0d", i),
               ({addr2, bank2, sel2, we2} === {iv[1:0], 3'd0, 2'd1, 1'b1}),
               $sformatf("addr=%0d bank=%0d sel=%b we=%b", addr2, bank2, sel2, we2),
               $sformatf("addr=%0d bank=0 sel=01 we=1", iv[1:0]));
         step();
      end
      wb_tile_start = 1'b0; wb_valid_out = 1'b0;
      #4;
      check("narrow_end_err", ({end2, err2, busy2} === 3'b110),
            $sformatf("end=%b err=%b busy=%b", end2, err2, busy2), "end=1 err=1 busy=0");
      step();
      #4;
      check("narrow_quiet", ({end2, err2, busy2} === 3'b000),
            $sformatf("end=%b err=%b busy=%b", end2, err2, busy2), "end=0 err=0 busy=0");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ctrl_wb_multi.md
Name: ctrl_wb_multi

Overview:
Parametrised successor to the two-engine write-back controller. Sequences output-buffer write-back for NUM_ENG compute engines (engine 0 = LUT/BS array, 1 = DSP/BP array, further slots for future arrays) in ascending engine order within one tile. Per-engine beat counts and bank-rotation modulus are latched at tile start. Zero-beat engines are skipped. Drives one shared address/bank/engine-select bus to the output buffers and signals tile completion to the top-level controller.

Parameters:
NUM_ENG, 2, number of engines drained per tile (1..8)
ADDR_W, 10, write-back address width driven to the output buffers
BANK_W, 3, width of the bank-enable rotation index
CNT_W, 16, width of the per-engine beat counters and times inputs

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
eng_out_times  input  NUM_ENG*CNT_W  beats per engine; latched on accepted wb_tile_start
eng_bank_num  input  NUM_ENG*BANK_W  banks per engine for rotation; latched with times; 0 treated as 1
wb_tile_start  input  1  start-of-tile pulse
wb_valid_out  input  1  upstream beat valid; one beat written per valid cycle while busy
wb_we  output  1  write strobe = wb_busy & wb_valid_out (combinational)
wb_eng_sel  output  NUM_ENG  one-hot active engine; 0 when idle
wb_bank_sel  output  BANK_W  current bank index
wb_addr  output  ADDR_W  low ADDR_W bits of the beat counter
wb_busy  output  1  high while draining
wb_tile_end  output  1  one-cycle pulse when the tile completes
wb_start_err  output  1  one-cycle pulse when wb_tile_start arrives while busy

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: state IDLE. Beat counter, bank index, engine index and latched regs = 0. All outputs 0.
- Reset mid-tile: abandons the tile; no wb_tile_end is issued.
- States: IDLE, DRAIN. DRAIN carries the engine index k.
- IDLE + wb_tile_start:
  - Latch times and bank_num for all engines.
  - Select the lowest k with times[k] != 0 and enter DRAIN(k) next cycle.
  - If all times are 0, stay IDLE and pulse wb_tile_end on the next cycle.
- DRAIN(k), on each wb_valid_out cycle:
  - wb_we = 1; address and bank are the current register values.
  - If beat counter == times[k]-1: reset counter and bank to 0 and move to the next higher k' with times[k'] != 0.
  - If no such k' exists: go to IDLE and pulse wb_tile_end next cycle (one cycle after the last write).
  - Otherwise: counter += 1; bank = (bank == bank_num[k]-1) ? 0 : bank+1.
- Cycles with wb_valid_out = 0: no state change, wb_we = 0.
- Engine handoff costs no bubble: a valid beat in the cycle after the last beat of k is written to k'.
- wb_tile_start while busy: ignored. Latched values are unchanged; wb_start_err pulses next cycle.
- wb_tile_start in the same cycle as the final beat: busy there, so it is ignored with an error pulse.
- Counter width is CNT_W. wb_addr = counter[ADDR_W-1:0] (wraps modulo 2^ADDR_W).
- Latency: start to first possible write = 1 cycle. Last write to wb_tile_end = 1 cycle.
- Outputs wb_eng_sel, wb_bank_sel, wb_addr and wb_busy are registered-state driven.

Optional Feature:
- Macro: WB_STALL_CNT_EN.
- Defined:
  - Adds output wb_stall_cycles (32 bits): counts busy cycles with wb_valid_out = 0.
  - Cleared on an accepted wb_tile_start and on rst; saturates at all-ones.
  - Value holds after wb_tile_end until the next accepted start.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. NUM_ENG=2, times={4,3}, bank_num={2,4}, valid held high -> 7 consecutive wb_we. Engine 0: addr 0,1,2,3, bank 0,1,0,1. Engine 1: addr 0,1,2, bank 0,1,2. wb_tile_end one cycle after the 7th write; wb_busy falls the same cycle.
2. times={0,5} -> engine 0 is never selected; first write goes to eng_sel=2'b10, addr 0; tile_end after 5 beats. times={0,0} -> no wb_we; tile_end pulses 1 cycle after start.
3. times={3,2}, valid toggling 1,0,1,0,... -> writes only on valid cycles; the total number of writes is 5. With WB_STALL_CNT_EN, wb_stall_cycles = 4 at tile end.
4. Second wb_tile_start during the 2nd beat of engine 0 -> wb_start_err pulses once; the sequence and latched times are unchanged; exactly one tile_end.
5. rst asserted during engine 1, beat 2 -> next cycle all outputs 0 and no tile_end. A new start then runs a clean tile from addr 0, bank 0.
6. ADDR_W=2, times={6,0}, bank_num={0,0} -> addr 0,1,2,3,0,1 and bank stuck at 0.
